// File: rtl/inst_encoder.sv
// MIPS-I instruction encoder: mnemonic + fields -> 32-bit word, queued in a DEPTH-entry FIFO.
// Optional macro INST_ENC_DSLOT_PAD_EN appends a delay-slot nop after every branch/jump word.
module inst_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_mnem,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic [31:0]      in_imme,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [31:0]      inst_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [31:0]      inst_cnt_q, inst_cnt_d;

  logic [5:0]    funct;
  logic [5:0]    op;
  logic [4:0]    regimm_rt;
  logic [4:0]    jalr_rd;
  logic [31:0]   enc_word;
  logic          enc_legal;
  logic          enc_branch;
  logic [PW-1:0] need_slots;
  logic [PW-1:0] used_slots;
  logic [PW-1:0] free_slots;
  logic          accept;
  logic          push;
  logic          pop;
  logic          unused_imme_hi;

  assign unused_imme_hi = ^in_imme[31:26];

  // R-type function codes, indexed by mnemonic id
  always_comb begin
    funct = 6'h00;
    case (in_mnem)
      6'd0:  funct = 6'h00;
      6'd1:  funct = 6'h02;
      6'd2:  funct = 6'h03;
      6'd3:  funct = 6'h04;
      6'd4:  funct = 6'h06;
      6'd5:  funct = 6'h07;
      6'd6:  funct = 6'h20;
      6'd7:  funct = 6'h21;
      6'd8:  funct = 6'h22;
      6'd9:  funct = 6'h23;
      6'd10: funct = 6'h24;
      6'd11: funct = 6'h25;
      6'd12: funct = 6'h26;
      6'd13: funct = 6'h27;
      6'd14: funct = 6'h2A;
      6'd15: funct = 6'h2B;
      6'd16: funct = 6'h18;
      6'd17: funct = 6'h19;
      6'd18: funct = 6'h1A;
      6'd19: funct = 6'h1B;
      6'd20: funct = 6'h10;
      6'd21: funct = 6'h12;
      6'd22: funct = 6'h11;
      6'd23: funct = 6'h13;
      6'd24: funct = 6'h08;
      6'd25: funct = 6'h09;
      default: funct = 6'h00;
    endcase
  end

  // Primary opcodes for I-type and J-type mnemonics
  always_comb begin
    op = 6'h00;
    case (in_mnem)
      6'd28: op = 6'h08;
      6'd29: op = 6'h09;
      6'd30: op = 6'h0A;
      6'd31: op = 6'h0B;
      6'd32: op = 6'h0C;
      6'd33: op = 6'h0D;
      6'd34: op = 6'h0E;
      6'd35: op = 6'h0F;
      6'd36: op = 6'h04;
      6'd37: op = 6'h05;
      6'd38: op = 6'h06;
      6'd39: op = 6'h07;
      6'd44: op = 6'h02;
      6'd45: op = 6'h03;
      6'd46: op = 6'h20;
      6'd47: op = 6'h24;
      6'd48: op = 6'h21;
      6'd49: op = 6'h25;
      6'd50: op = 6'h23;
      6'd51: op = 6'h28;
      6'd52: op = 6'h29;
      6'd53: op = 6'h2B;
      default: op = 6'h00;
    endcase
  end

  always_comb begin
    regimm_rt = 5'b00000;
    case (in_mnem)
      6'd41: regimm_rt = 5'b00001;
      6'd42: regimm_rt = 5'b10000;
      6'd43: regimm_rt = 5'b10001;
      default: regimm_rt = 5'b00000;
    endcase
  end

  // jalr with no explicit link register links through $ra
  assign jalr_rd = (in_rd == 5'd0) ? 5'd31 : in_rd;

  always_comb begin
    enc_word   = 32'h0;
    enc_legal  = 1'b1;
    enc_branch = 1'b0;
    case (in_mnem)
      6'd0, 6'd1, 6'd2:
        enc_word = {6'h00, 5'd0, in_rt, in_rd, in_imme[4:0], funct};
      6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10,
      6'd11, 6'd12, 6'd13, 6'd14, 6'd15:
        enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, funct};
      6'd16, 6'd17, 6'd18, 6'd19:
        enc_word = {6'h00, in_rs, in_rt, 5'd0, 5'd0, funct};
      6'd20, 6'd21:
        enc_word = {6'h00, 5'd0, 5'd0, in_rd, 5'd0, funct};
      6'd22, 6'd23:
        enc_word = {6'h00, in_rs, 5'd0, 5'd0, 5'd0, funct};
      6'd24: begin
        enc_word   = {6'h00, in_rs, 5'd0, 5'd0, 5'd0, funct};
        enc_branch = 1'b1;
      end
      6'd25: begin
        enc_word   = {6'h00, in_rs, in_rt, jalr_rd, 5'd0, funct};
        enc_branch = 1'b1;
      end
      6'd26: enc_word = 32'h0000000C;
      6'd27: enc_word = 32'h0000000D;
      6'd28, 6'd29, 6'd30, 6'd31, 6'd32, 6'd33, 6'd34,
      6'd46, 6'd47, 6'd48, 6'd49, 6'd50, 6'd51, 6'd52, 6'd53:
        enc_word = {op, in_rs, in_rt, in_imme[15:0]};
      6'd35: enc_word = {op, 5'd0, in_rt, in_imme[15:0]};
      6'd36, 6'd37: begin
        enc_word   = {op, in_rs, in_rt, in_imme[15:0]};
        enc_branch = 1'b1;
      end
      6'd38, 6'd39: begin
        enc_word   = {op, in_rs, 5'd0, in_imme[15:0]};
        enc_branch = 1'b1;
      end
      6'd40, 6'd41, 6'd42, 6'd43: begin
        enc_word   = {6'h01, in_rs, regimm_rt, in_imme[15:0]};
        enc_branch = 1'b1;
      end
      6'd44, 6'd45: begin
        enc_word   = {op, in_imme[25:0]};
        enc_branch = 1'b1;
      end
      6'd54: enc_word = {6'h10, 5'b00000, in_rt, in_rd, 11'd0};
      6'd55: enc_word = {6'h10, 5'b00100, in_rt, in_rd, 11'd0};
      6'd56: enc_word = 32'h42000018;
      default: enc_legal = 1'b0;
    endcase
  end

  // Readiness depends only on registered occupancy, never on out_ready
  assign used_slots = wr_ptr_q - rd_ptr_q;
  assign free_slots = DEPTH_P - used_slots;
`ifdef INST_ENC_DSLOT_PAD_EN
  assign need_slots = (enc_legal && enc_branch) ? PW'(2) : PW'(1);
`else
  assign need_slots = PW'(1);
`endif
  assign in_ready  = (free_slots >= need_slots);
  assign accept    = in_valid & in_ready;
  assign push      = accept & enc_legal;
  assign out_valid = (wr_ptr_q != rd_ptr_q);
  assign pop       = out_valid & out_ready;
  assign out_inst  = out_valid ? mem_q[rd_ptr_q[AW-1:0]] : 32'h0;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    err_d      = accept & ~enc_legal;
    err_cnt_d  = err_cnt_q;
    inst_cnt_d = inst_cnt_q;
    if (push) begin
`ifdef INST_ENC_DSLOT_PAD_EN
      wr_ptr_d = wr_ptr_q + (enc_branch ? PW'(2) : PW'(1));
`else
      wr_ptr_d = wr_ptr_q + PW'(1);
`endif
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PW'(1);
      inst_cnt_d = inst_cnt_q + 32'd1;
    end
    if (accept && !enc_legal && (err_cnt_q != {CNT_W{1'b1}}))
      err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      inst_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      inst_cnt_q <= inst_cnt_d;
    end
  end

  // Storage needs no reset: reads are masked until the pointers say a slot is valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= enc_word;
`ifdef INST_ENC_DSLOT_PAD_EN
      if (enc_branch)
        mem_q[AW'(wr_ptr_q[AW-1:0] + AW'(1))] <= 32'h0;
`endif
    end
  end

  assign err      = err_q;
  assign err_cnt  = err_cnt_q;
  assign inst_cnt = inst_cnt_q;
endmodule

// File: tb/tb_inst_encoder.sv
// Directed-vector bench for inst_encoder; expectations adapt when INST_ENC_DSLOT_PAD_EN is defined.
module tb_inst_encoder;
`ifdef INST_ENC_DSLOT_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_mnem = 6'd7;
  logic [4:0]  in_rs = 5'd0;
  logic [4:0]  in_rt = 5'd0;
  logic [4:0]  in_rd = 5'd0;
  logic [31:0] in_imme = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic        err;
  logic [15:0] err_cnt;
  logic [31:0] inst_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  inst_encoder #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imme(in_imme),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .err(err), .err_cnt(err_cnt), .inst_cnt(inst_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Present one request and hold it until accepted (bounded)
  task automatic send(input logic [5:0] m, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [31:0] imm);
    int n = 0;
    in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd; in_imme = imm;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      check("send_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] exp);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check(tag, out_inst, exp);
    if (out_valid) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      exp_cnt++;
    end
  endtask

  // Encode one request, check it appears at once, drain it (plus its nop if padded)
  task automatic xact(input string tag, input logic [5:0] m, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] imm,
                      input logic [31:0] exp, input bit is_br);
    send(m, rs, rt, rd, imm);
    check({tag, "_lat"}, 32'(out_valid), 32'd1);
    pop_expect(tag, exp);
    if (PAD && is_br) pop_expect({tag, "_nop"}, 32'h0);
    check({tag, "_fifo_empty"}, 32'(out_valid), 32'd0);
    $display("[TB] xact %s mnem=%0d word=%08h", tag, m, exp);
  endtask

  initial begin
    #1 resetn = 1'b0;
    #20;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_inst", out_inst, 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_inst_cnt", inst_cnt, 32'd0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;

    // Two queued words drained in order
    send(6'd7, 5'd1, 5'd2, 5'd3, 32'h0);
    check("addu_lat", 32'(out_valid), 32'd1);
    check("addu_head", out_inst, 32'h00221821);
    send(6'd50, 5'd29, 5'd8, 5'd0, 32'hFFFFFFFC);
    pop_expect("addu", 32'h00221821);
    pop_expect("lw", 32'h8FA8FFFC);
    check("inst_cnt_2", inst_cnt, 32'd2);
    $display("[TB] xact addu+lw drained inst_cnt=%0d", inst_cnt);

    xact("sll",    6'd0,  5'd0,  5'd3,  5'd2,  32'h4,        32'h00031100, 1'b0);
    xact("jalr",   6'd25, 5'd4,  5'd0,  5'd0,  32'h0,        32'h0080F809, 1'b1);
    xact("jal",    6'd45, 5'd0,  5'd0,  5'd0,  32'h00100000, 32'h0C100000, 1'b1);
    xact("beq",    6'd36, 5'd1,  5'd2,  5'd0,  32'h10,       32'h10220010, 1'b1);
    xact("sra",    6'd2,  5'd5,  5'd3,  5'd2,  32'h1F,       32'h000317C3, 1'b0);
    xact("mult",   6'd16, 5'd1,  5'd2,  5'd3,  32'h0,        32'h00220018, 1'b0);
    xact("mfhi",   6'd20, 5'd1,  5'd2,  5'd4,  32'h0,        32'h00002010, 1'b0);
    xact("jr",     6'd24, 5'd31, 5'd1,  5'd2,  32'h0,        32'h03E00008, 1'b1);
    xact("syscall",6'd26, 5'd3,  5'd3,  5'd3,  32'h0,        32'h0000000C, 1'b0);
    xact("ori",    6'd33, 5'd1,  5'd2,  5'd0,  32'hFFFF8001, 32'h34228001, 1'b0);
    xact("lui",    6'd35, 5'd7,  5'd9,  5'd0,  32'h1234,     32'h3C091234, 1'b0);
    xact("blez",   6'd38, 5'd4,  5'd5,  5'd0,  32'h3,        32'h18800003, 1'b1);
    xact("bltzal", 6'd42, 5'd3,  5'd7,  5'd0,  32'hFFFE,     32'h0470FFFE, 1'b1);
    xact("j",      6'd44, 5'd0,  5'd0,  5'd0,  32'hFFFFFFFF, 32'h0BFFFFFF, 1'b1);
    xact("sw",     6'd53, 5'd29, 5'd31, 5'd0,  32'h4,        32'hAFBF0004, 1'b0);
    xact("mfc0",   6'd54, 5'd0,  5'd5,  5'd12, 32'h0,        32'h40056000, 1'b0);
    xact("mtc0",   6'd55, 5'd0,  5'd5,  5'd12, 32'h0,        32'h40856000, 1'b0);
    xact("eret",   6'd56, 5'd0,  5'd0,  5'd0,  32'h0,        32'h42000018, 1'b0);
    check("inst_cnt_run", inst_cnt, 32'(exp_cnt));

    // Illegal mnemonic: accepted, nothing queued, one-cycle err
    send(6'd60, 5'd1, 5'd2, 5'd3, 32'h0);
    check("ill_err", 32'(err), 32'd1);
    check("ill_no_valid", 32'(out_valid), 32'd0);
    check("ill_err_cnt", 32'(err_cnt), 32'd1);
    @(posedge clk); #1;
    check("ill_err_drop", 32'(err), 32'd0);
    $display("[TB] xact illegal mnem=60 err_cnt=%0d", err_cnt);
    xact("post_ill", 6'd7, 5'd1, 5'd2, 5'd3, 32'h0, 32'h00221821, 1'b0);

    // Fill, backpressure, single pop, refill across pointer wrap
    for (int k = 0; k < 4; k++) send(6'd7, 5'd1, 5'd2, 5'(k), 32'h0);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_head", out_inst, 32'h00220021);
    @(posedge clk); #1;
    check("full_stable", out_inst, 32'h00220021);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_cnt++;
    check("after_pop_ready", 32'(in_ready), 32'd1);
    check("after_pop_head", out_inst, 32'h00220821);
    send(6'd7, 5'd1, 5'd2, 5'd4, 32'h0);
    pop_expect("wrap1", 32'h00220821);
    pop_expect("wrap2", 32'h00221021);
    pop_expect("wrap3", 32'h00221821);
    pop_expect("wrap4", 32'h00222021);
    check("wrap_inst_cnt", inst_cnt, 32'(exp_cnt));
    $display("[TB] xact full/wrap sequence inst_cnt=%0d", inst_cnt);

    // Asynchronous reset with words queued
    for (int k = 0; k < 3; k++) send(6'd7, 5'd1, 5'd2, 5'(k), 32'h0);
    #2 resetn = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_inst_cnt", inst_cnt, 32'd0);
    check("arst_err_cnt", 32'(err_cnt), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    exp_cnt = 0;
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    $display("[TB] xact async reset with 3 queued words");
    xact("post_rst", 6'd50, 5'd29, 5'd8, 5'd0, 32'hFFFFFFFC, 32'h8FA8FFFC, 1'b0);
    check("post_rst_cnt", inst_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
